// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller: sequences PC/IR/memory/regfile enables and ALU/mux selects.
// Latency: Moore outputs follow the state register; ImmSrc follows op and BEQ's PCWrite follows zero combinationally.
// Backpressure: none; an unsupported instruction parks the FSM in TRAP until reset.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEMADR   = 4'd3;
    localparam logic [3:0] S_MEMREAD  = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_MEMWRITE = 4'd6;
    localparam logic [3:0] S_EXECR    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW)                next_state = S_MEMADR;
                else if (op == OP_R    && funct3 == 3'b000)    next_state = S_EXECR;
                else if (op == OP_ADDI && funct3 == 3'b000)    next_state = S_EXECI;
                else if (op == OP_BEQ  && funct3 == 3'b000)    next_state = S_BEQ;
                else if (op == OP_JAL)                         next_state = S_JAL;
                else                                           next_state = S_TRAP;
            end
            S_MEMADR:   next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = {2'b00, funct7b5};
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            // zero only matters here; glitches elsewhere never reach PCWrite
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and random instruction streams checked against a per-instruction sequence model.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal, instr_done;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pcw, adrsrc, memw, irw, regw;
        logic [1:0] res, srca, srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       ill, done;
        logic [3:0] st;
    } obs_t;

    obs_t obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, illegal, instr_done, state};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .instr_done(instr_done),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction -> list of states visited, FETCH through last state.
    function automatic void build_seq(input logic [6:0] o, input logic [2:0] f3, output int s[$]);
        if (o == LW)                          s = {1, 2, 3, 4, 5};
        else if (o == SW)                     s = {1, 2, 3, 6};
        else if (o == RT   && f3 == 3'b000)   s = {1, 2, 7, 9};
        else if (o == ADDI && f3 == 3'b000)   s = {1, 2, 8, 9};
        else if (o == BEQ  && f3 == 3'b000)   s = {1, 2, 10};
        else if (o == JAL)                    s = {1, 2, 11, 9};
        else                                  s = {1, 2, 12};
    endfunction

    // Control table: what each named state must drive.
    function automatic obs_t model(input int st, input logic [6:0] o, input logic f7, input logic z);
        obs_t e;
        e = '0;
        e.st = 4'(st);
        e.imm = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        case (st)
            1:  begin e.pcw = 1; e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; end
            2:  begin e.srca = 2'b01; e.srcb = 2'b01; end
            3:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            4:  e.adrsrc = 1;
            5:  begin e.res = 2'b01; e.regw = 1; e.done = 1; end
            6:  begin e.adrsrc = 1; e.memw = 1; e.done = 1; end
            7:  begin e.srca = 2'b10; e.aluc = f7 ? 3'b001 : 3'b000; end
            8:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            9:  begin e.regw = 1; e.done = 1; end
            10: begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; e.done = 1; end
            11: begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
            12: e.ill = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic test_reset;
        obs_t e;
        rst_n = 1'b0;
        op = LW;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = model(0, op, funct7b5, zero);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %h want %h", c, obs, e);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        e = model(1, op, funct7b5, zero);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_first_fetch got %h want %h", obs, e);
        end
    endtask

    task automatic test_directed;
        logic [6:0] d_op [8] = '{LW, SW, RT, RT, ADDI, BEQ, BEQ, JAL};
        logic       d_f7 [8] = '{0, 1, 1, 0, 1, 0, 1, 0};
        logic       d_z  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        int s[$];
        int nd;
        obs_t e;
        for (int k = 0; k < 8; k++) begin
            op = d_op[k];
            funct3 = 3'b000;
            funct7b5 = d_f7[k];
            build_seq(op, funct3, s);
            nd = 0;
            for (int i = 0; i < s.size(); i++) begin
                zero = (s[i] == 10) ? d_z[k] : 1'($urandom);
                #1;
                e = model(s[i], op, funct7b5, zero);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL directed%0d step%0d got %h want %h", k, i, obs, e);
                end
                nd += int'(instr_done);
                @(negedge clk);
            end
            checks++;
            if (nd != 1) begin
                errors++;
                $display("FAIL directed%0d_done_pulses got %0d want 1", k, nd);
            end
        end
    endtask

    task automatic test_illegal;
        logic [6:0] i_op [2] = '{7'b0110111, RT};
        logic [2:0] i_f3 [2] = '{3'b000, 3'b111};
        obs_t e;
        for (int k = 0; k < 2; k++) begin
            op = i_op[k];
            funct3 = i_f3[k];
            funct7b5 = 1'b0;
            for (int c = 0; c < 22; c++) begin
                zero = 1'($urandom);
                #1;
                e = model(c == 0 ? 1 : c == 1 ? 2 : 12, op, funct7b5, zero);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL illegal%0d cyc%0d got %h want %h", k, c, obs, e);
                end
                @(negedge clk);
            end
            #2 rst_n = 1'b0;
            #1;
            e = model(0, op, funct7b5, zero);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal%0d_reset got %h want %h", k, obs, e);
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            e = model(1, op, funct7b5, zero);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal%0d_refetch got %h want %h", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_sw;
        obs_t e;
        int memw_seen;
        op = SW;
        funct3 = 3'b010;
        funct7b5 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            e = model(c + 1, op, funct7b5, zero);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL midsw_pre cyc%0d got %h want %h", c, obs, e);
            end
            if (c < 2) @(negedge clk);
        end
        memw_seen = 0;
        #2 rst_n = 1'b0;
        #1;
        e = model(0, op, funct7b5, zero);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL midsw_abort got %h want %h", obs, e);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1 memw_seen += int'(MemWrite);
        end
        checks++;
        if (memw_seen != 0) begin
            errors++;
            $display("FAIL midsw_memwrite_pulses got %0d want 0", memw_seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = model(1, op, funct7b5, zero);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL midsw_restart got %h want %h", obs, e);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [6] = '{LW, SW, RT, ADDI, BEQ, JAL};
        int s[$];
        int nd;
        logic bz;
        obs_t e;
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 5)];
            funct3 = (op == LW || op == SW || op == JAL) ? 3'($urandom) : 3'b000;
            funct7b5 = 1'($urandom);
            bz = 1'($urandom);
            build_seq(op, funct3, s);
            nd = 0;
            for (int i = 0; i < s.size(); i++) begin
                zero = (s[i] == 10) ? bz : 1'($urandom);
                #1;
                e = model(s[i], op, funct7b5, zero);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL random%0d step%0d op=%b got %h want %h", k, i, op, obs, e);
                end
                nd += int'(instr_done);
                @(negedge clk);
            end
            checks++;
            if (nd != 1) begin
                errors++;
                $display("FAIL random%0d_done_pulses got %0d want 1", k, nd);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_illegal;
        test_reset_mid_sw;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
